// File: rtl/rsa_sequencer.sv
// Host-side command sequencer for a small RSA encryption core: latches commands,
// pulses the core's input type for one cycle and returns ciphertext results.
module rsa_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [12:0] cmd_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [12:0] res_plain,
  output logic [12:0] core_data,
  output logic [2:0]  core_type,
  input  logic        core_done,
  input  logic [15:0] core_result,
  output logic        busy,
  output logic        err
);

  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 12) ? $clog2(TIMEOUT_CYCLES + 1) : 12;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_GAP, S_WAIT, S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic               gap_q, gap_d;
  logic [1:0]         type_q, type_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic [12:0]        core_data_q, core_data_d;
  logic [2:0]         core_type_q, core_type_d;
  logic               res_valid_q, res_valid_d;
  logic [15:0]        res_data_q, res_data_d;
  logic [12:0]        res_plain_q, res_plain_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    type_d      = type_q;
    tmo_d       = tmo_q;
    core_data_d = core_data_q;
    res_data_d  = res_data_q;
    res_plain_d = res_plain_q;
    err_d       = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_type == 2'd3) begin
            err_d = 1'b1;
          end else begin
            core_data_d = cmd_data;
            type_d      = cmd_type;
            state_d     = S_SETUP;
          end
        end
      end
      S_SETUP: state_d = S_PULSE;
      S_PULSE: begin
        gap_d   = 1'b0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q) begin
          tmo_d   = '0;
          state_d = (type_q == 2'd0) ? S_WAIT : S_IDLE;
        end else begin
          gap_d = 1'b1;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (core_done) begin
          res_data_d  = core_result;
          res_plain_d = core_data_q;
          state_d     = S_RESP;
        end else if (tmo_d == CNT_W'(TIMEOUT_CYCLES)) begin
          res_data_d  = '1;
          res_plain_d = core_data_q;
          err_d       = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they align with the state they describe.
    core_type_d = (state_d == S_PULSE) ? ({1'b0, type_d} + 3'd1) : 3'd0;
    res_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gap_q       <= 1'b0;
      type_q      <= 2'd0;
      tmo_q       <= '0;
      core_data_q <= '0;
      core_type_q <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_plain_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      type_q      <= type_d;
      tmo_q       <= tmo_d;
      core_data_q <= core_data_d;
      core_type_q <= core_type_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_plain_q <= res_plain_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_plain = res_plain_q;
  assign core_data = core_data_q;
  assign core_type = core_type_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rsa_sequencer.sv
// Randomized scoreboard bench for rsa_sequencer with a behavioural RSA core model.
module tb_rsa_sequencer;
  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [12:0] cmd_data;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [12:0] res_plain;
  logic [12:0] core_data;
  logic [2:0]  core_type;
  logic        core_done;
  logic [15:0] core_result;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  rsa_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_data(cmd_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_plain(res_plain),
    .core_data(core_data), .core_type(core_type), .core_done(core_done),
    .core_result(core_result), .busy(busy), .err(err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // m^e mod n by repeated multiplication
  function automatic logic [15:0] modexp(input logic [12:0] m, input logic [12:0] e,
                                         input logic [12:0] n);
    longint r;
    if (n == 0) return 16'd0;
    r = 1 % longint'(n);
    for (int i = 0; i < int'(e); i++) r = (r * longint'(m)) % longint'(n);
    return 16'(r);
  endfunction

  // Behavioural core: config loads, delayed result, optional stale done after start
  logic [12:0] core_e = 13'd17;
  logic [12:0] core_n = 13'd3233;
  logic [15:0] core_new = '0;
  int core_rem = -1;
  int core_hold = 0;
  int cfg_delay = 2;
  int cfg_hold = 0;
  bit core_dead = 1'b0;

  initial begin
    core_done = 1'b0;
    core_result = '0;
  end

  always @(posedge clk) begin
    if (core_type == 3'd2) core_e <= core_data;
    else if (core_type == 3'd3) core_n <= core_data;
    if (core_type == 3'd1) begin
      core_new  <= modexp(core_data, core_e, core_n);
      core_rem  <= cfg_delay;
      core_hold <= cfg_hold;
      if (cfg_hold == 0) core_done <= 1'b0;
    end else if (core_rem > 0) begin
      core_rem <= core_rem - 1;
      if (core_hold > 1) core_hold <= core_hold - 1;
      else begin
        core_hold <= 0;
        core_done <= 1'b0;
      end
    end else if (core_rem == 0) begin
      if (!core_dead) begin
        core_done   <= 1'b1;
        core_result <= core_new;
      end
      core_rem <= -1;
    end
  end

  typedef struct {
    logic [15:0] res;
    logic [12:0] plain;
  } exp_t;
  exp_t sbq[$];
  logic [12:0] e_m = 13'd17;
  logic [12:0] n_m = 13'd3233;

  // 0: random, 1: held low, 2: held high
  int ready_mode = 0;
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      res_ready = (ready_mode == 1) ? 1'b0 :
                  (ready_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  int pulses = 0;
  initial forever begin
    @(negedge clk);
    if (!rst && core_type != 3'd0) pulses++;
  end

  // Scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (!rst && res_valid && res_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_result", {16'd0, res_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t x;
        x = sbq.pop_front();
        chk("res_data", 32'(res_data), 32'(x.res));
        chk("res_plain", 32'(res_plain), 32'(x.plain));
      end
    end
  end

  // Protocol checker: result held under backpressure, core bus stable while busy
  logic        p_valid = 1'b0, p_ready = 1'b0, p_busy = 1'b0;
  logic [15:0] p_data = '0;
  logic [12:0] p_plain = '0, p_cd = '0;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (p_valid && !p_ready) begin
        chk("hold_valid", 32'(res_valid), 32'd1);
        chk("hold_data", 32'(res_data), 32'(p_data));
        chk("hold_plain", 32'(res_plain), 32'(p_plain));
      end
      if (res_valid) chk("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
      if (p_busy && busy) chk("core_data_stable", 32'(core_data), 32'(p_cd));
    end
    p_valid = res_valid; p_ready = res_ready; p_data = res_data;
    p_plain = res_plain; p_busy = busy; p_cd = core_data;
  end

  // Called at posedge+#1; returns at posedge+#1 after the transfer edge.
  task automatic send(input logic [1:0] t, input logic [12:0] d);
    int guard = 0;
    exp_t x;
    cmd_type = t; cmd_data = d; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    if (cmd_ready) begin
      case (t)
        2'd0: begin
          x.res = core_dead ? 16'hFFFF : modexp(d, e_m, n_m);
          x.plain = d;
          sbq.push_back(x);
        end
        2'd1: e_m = d;
        2'd2: n_m = d;
        default: ;
      endcase
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy || sbq.size() != 0) && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    #1;
    chk("drain", 32'(busy || sbq.size() != 0), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_data"}, 32'(res_data), 32'd0);
    chk({tag, "_res_plain"}, 32'(res_plain), 32'd0);
    chk({tag, "_core_data"}, 32'(core_data), 32'd0);
    chk({tag, "_core_type"}, 32'(core_type), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int exp_ct[4];
    int lat;
    int p0;
    logic [12:0] cd0;
    logic [15:0] held;
    exp_ct = '{0, 1, 0, 0};
    rst = 1'b1; cmd_valid = 1'b0; cmd_type = '0; cmd_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;

    // Default keys, core_type sequence over SETUP..GAP
    send(2'd0, 13'd65);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("core_type_seq", 32'(core_type), 32'(exp_ct[i]));
    end
    @(posedge clk); #1;
    wait_idle();
    send(2'd0, 13'd0);
    wait_idle();

    // Stale core_done held into the next op's GAP
    cfg_hold = 2; cfg_delay = 6;
    send(2'd0, 13'd2);
    wait_idle();
    cfg_hold = 0; cfg_delay = 2;

    // Backpressure: result held for 5 cycles, then released
    ready_mode = 1;
    send(2'd0, 13'd123);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!res_valid && lat < 100);
    chk("bp_valid_seen", 32'(res_valid), 32'd1);
    held = res_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_data", 32'(res_data), 32'(held));
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    ready_mode = 2;
    @(posedge clk);
    @(negedge clk);
    chk("bp_valid_before_hs", 32'(res_valid), 32'd1);
    @(negedge clk);
    chk("bp_valid_after_hs", 32'(res_valid), 32'd0);
    chk("bp_idle_after_hs", 32'(cmd_ready), 32'd1);
    ready_mode = 0;
    @(posedge clk); #1;
    wait_idle();

    for (int i = 0; i < 10; i++) begin
      cfg_delay = $urandom_range(0, 6);
      cfg_hold = $urandom_range(0, 2);
      send(2'd0, 13'($urandom_range(0, 3232)));
      wait_idle();
    end

    // Reserved command
    p0 = pulses; cd0 = core_data;
    send(2'd3, 13'd77);
    repeat (6) @(negedge clk);
    chk("rsv_err", 32'(err), 32'd1);
    chk("rsv_no_pulse", 32'(pulses), 32'(p0));
    chk("rsv_busy", 32'(busy), 32'd0);
    chk("rsv_core_data", 32'(core_data), 32'(cd0));
    @(posedge clk); #1;

    // Reset during WAIT, late core_done ignored
    cfg_hold = 0; cfg_delay = 30;
    send(2'd0, 13'd100);
    repeat (8) @(posedge clk);
    #1;
    chk("wait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    sbq.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    repeat (30) @(negedge clk);
    chk("late_done_busy", 32'(busy), 32'd0);
    chk("late_done_valid", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    cfg_delay = 3;
    send(2'd0, 13'd65);
    wait_idle();

    // Small key set: no results for config commands
    p0 = pulses;
    send(2'd1, 13'd3);
    send(2'd2, 13'd15);
    wait_idle();
    chk("cfg_pulses", 32'(pulses), 32'(p0 + 2));
    send(2'd0, 13'd2);
    wait_idle();
    send(2'd0, 13'd4);
    wait_idle();
    send(2'd0, 13'd14);
    wait_idle();

    // Random mix of key changes and encrypts
    for (int i = 0; i < 20; i++) begin
      int r;
      cfg_delay = $urandom_range(0, 6);
      cfg_hold = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      if (r == 0) send(2'd1, 13'($urandom_range(1, 40)));
      else if (r == 1) send(2'd2, 13'($urandom_range(2, 8191)));
      else send(2'd0, 13'($urandom_range(0, 8191)));
      wait_idle();
    end

    // Dead core: timeout after TMO WAIT cycles
    core_dead = 1'b1; cfg_hold = 0; cfg_delay = 1;
    ready_mode = 1;
    send(2'd0, 13'd5);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!res_valid && lat < 100);
    chk("timeout_latency", 32'(lat), 32'(5 + TMO));
    chk("timeout_err", 32'(err), 32'd1);
    ready_mode = 0;
    @(posedge clk); #1;
    wait_idle();
    core_dead = 1'b0; cfg_delay = 2;
    send(2'd0, 13'd7);
    wait_idle();
    chk("err_sticky", 32'(err), 32'd1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rsa_sequencer.md
RSA_SEQUENCER -- requirements
Module: rsa_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 4095; maximum cycles spent in WAIT before abort.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  host command present.
REQ-005 cmd_ready  output  1  sequencer accepts command this cycle.
REQ-006 cmd_type  input  2  0 = encrypt, 1 = set e, 2 = set n, 3 = reserved.
REQ-007 cmd_data  input  13  plaintext, e or n value.
REQ-008 res_valid  output  1  encrypt result present.
REQ-009 res_ready  input  1  host consumes result.
REQ-010 res_data  output  16  ciphertext; 16'hFFFF on timeout.
REQ-011 res_plain  output  13  plaintext that produced res_data.
REQ-012 core_data  output  13  data bus to encryption core.
REQ-013 core_type  output  3  core input_data_type: 0 idle, 1 encrypt, 2 load e, 3 load n.
REQ-014 core_done  input  1  core completion flag; may remain high from the previous operation.
REQ-015 core_result  input  16  core output_data.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 err  output  1  sticky error flag.

Function
REQ-018 FSM states: IDLE, SETUP, PULSE, GAP, WAIT, RESP.
REQ-019 cmd_ready = 1 only in IDLE; a command transfers when cmd_valid && cmd_ready.
REQ-020 On transfer: cmd_data latched into core_data; cmd_type latched; IDLE -> SETUP.
REQ-021 Reserved cmd_type 3: consumed, err set, FSM stays IDLE, core untouched.
REQ-022 SETUP (1 cycle): core_type = 0, core_data stable; -> PULSE.
REQ-023 PULSE (exactly 1 cycle): core_type = 1/2/3 for encrypt/set e/set n; -> GAP.
REQ-024 GAP (exactly 2 cycles): core_type = 0; core_done ignored; config commands -> IDLE; encrypt -> WAIT.
REQ-025 WAIT: core_type = 0; the first cycle with core_done = 1 captures core_result into res_data and core_data into res_plain; -> RESP.
REQ-026 WAIT timeout counter: 12-bit minimum, cleared on WAIT entry; when it reaches TIMEOUT_CYCLES without core_done -> res_data = 16'hFFFF, err set, -> RESP.
REQ-027 core_data held constant from the transfer until the next accepted command; it never changes during SETUP through RESP.
REQ-028 RESP: res_valid = 1; res_data and res_plain stable until res_ready = 1; on handshake -> IDLE, res_valid low the next cycle.
REQ-029 Config commands never assert res_valid.
REQ-030 A cmd_valid arriving in RESP is not accepted in the same cycle as the result handshake; it is accepted earliest the following IDLE cycle.
REQ-031 err is cleared only by rst.
REQ-032 Minimum latency, encrypt transfer to res_valid: 4 cycles plus core compute time.

Reset
REQ-033 When rst = 1 at a clock edge, the sequencer enters IDLE; cmd_ready = 1 from the cycle after reset is released.
REQ-034 Reset values: res_valid 0, res_data 0, res_plain 0, core_data 0, core_type 0, busy 0, err 0, timeout counter 0.
REQ-035 Reset in any state, including mid-WAIT or RESP, aborts the operation without emitting a result; a late core_done after reset is ignored while IDLE.

Verification
REQ-036 Core defaults e = 17, n = 3233; encrypt 65 -> res_data = 2790, res_plain = 65; encrypt 0 -> 0; core_type observed as 0,1,0,0 over SETUP..GAP.
REQ-037 Set e = 3, then set n = 15 -> no res_valid; encrypt 2 -> 8; encrypt 4 -> 4; encrypt 14 -> 14.
REQ-038 Hold res_ready low for 5 cycles after res_valid -> res_data and res_valid stable, cmd_ready = 0; res_ready high -> IDLE next cycle.
REQ-039 Tie core_done low with TIMEOUT_CYCLES = 16, encrypt 5 -> res_valid after 16 WAIT cycles, res_data = 16'hFFFF, err = 1 and persists through later good commands.
REQ-040 Issue cmd_type 3 -> err = 1, no core pulse, no res_valid; assert rst during WAIT -> all outputs at reset values, and the next encrypt 65 returns 2790.
REQ-041 Hold core_done high from the prior op into the next encrypt -> GAP masking prevents capture of the stale result; the correct new ciphertext is returned.
